mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 64, data-memory depth in 32-bit words (power of two, 16..1024).
REQ-002 SHALL provide parameter MEM_LATENCY, default 2, cycles a load/store occupies the memory (1..15).
REQ-003 SHALL provide ports, one per line:
 clk  input  1  clock, rising edge
 reset  input  1  asynchronous active-low reset, 0 = reset
 in_valid  input  1  EX result valid
 in_ready  output  1  stage can accept
 alu_result  input  32  EX resultOut, byte address for loads/stores
 write_data  input  32  store data (rt)
 mem_read  input  1  load
 mem_write  input  1  store
 reg_write  input  1  writeback enable
 mem_to_reg  input  1  1 = writeback load data, 0 = alu_result
 write_reg  input  5  destination register
 branch  input  1  branch instruction
 zero  input  1  EX zero flag
 pcout  input  32  EX branch target
 pc_src  output  1  branch taken pulse
 branch_target  output  32  registered pcout
 out_valid  output  1  writeback valid pulse
 wb_data  output  32  writeback data
 wb_reg  output  5  writeback register
 wb_reg_write  output  1  writeback enable
 misalign_err  output  1  sticky misaligned-access flag

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, DONE; in_ready = 1 in IDLE and DONE, 0 in ACCESS.
REQ-005 SHALL accept a transaction on any rising edge with in_valid & in_ready; otherwise inputs ignored.
REQ-006 On accepting a non-memory op (mem_read = mem_write = 0), SHALL go to DONE with wb_data = alu_result (latency 1, back-to-back throughput 1/cycle).
REQ-007 On accepting a memory op, SHALL enter ACCESS for exactly MEM_LATENCY cycles, then DONE; acceptance at edge k gives out_valid after edge k+MEM_LATENCY.
REQ-008 Store SHALL write write_data to word index alu_result[log2(DEPTH_WORDS)+1:2] on the final ACCESS edge only; load SHALL capture that word into wb_data on the same edge.
REQ-009 Addresses beyond DEPTH_WORDS*4 SHALL wrap (upper bits ignored).
REQ-010 mem_read & mem_write both 1 SHALL be treated as a store; wb_data = alu_result.
REQ-011 wb_data SHALL be load data when mem_to_reg = 1 and mem_read = 1, else alu_result.
REQ-012 out_valid SHALL be 1 exactly one cycle per accepted transaction (in DONE); wb_reg and wb_reg_write SHALL hold the accepted values and are meaningful only while out_valid = 1.
REQ-013 From DONE: accept → next state per REQ-006/007; no accept → IDLE.
REQ-014 pc_src SHALL be 1 for the one cycle after accepting with branch & zero; branch_target SHALL capture pcout on every accept.
REQ-015 Downstream has no backpressure; out_valid is never held.

Reset
REQ-016 reset = 0 SHALL asynchronously force state IDLE, in_ready 1, out_valid 0, pc_src 0, wb_data 0, wb_reg 0, wb_reg_write 0, branch_target 0, misalign_err 0.
REQ-017 Reset during ACCESS SHALL abort the access; a store not yet at its final ACCESS edge SHALL NOT modify memory.
REQ-018 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-019 Macro MISALIGN_TRAP_EN defined: a load/store with alu_result[1:0] != 0 SHALL skip memory access (no write, wb_data = 0), wb_reg_write = 0 on its out_valid, and set misalign_err until reset; timing unchanged.
REQ-020 MISALIGN_TRAP_EN undefined: alu_result[1:0] ignored, access proceeds word-aligned, misalign_err tied 0.

Verification
REQ-021 Store 0xDEADBEEF to 0x10, then load 0x10 with mem_to_reg = 1 → second out_valid shows wb_data = 0xDEADBEEF; each out_valid exactly 2 cycles after accept.
REQ-022 Three consecutive ALU ops with alu_result 1, 2, 3 → out_valid high three consecutive cycles, wb_data 1, 2, 3; in_ready stays 1.
REQ-023 branch = 1, zero = 1, pcout = 0x40 → pc_src = 1 for one cycle, branch_target = 0x40; zero = 0 → pc_src stays 0.
REQ-024 Store 0x55 to 0x100 with DEPTH_WORDS = 64 → load from 0x0 returns 0x55 (wrap).
REQ-025 Store 0x1234 to 0x20 with reset pulsed low after 1 ACCESS cycle → later load of 0x20 returns prior value, out_valid never asserted for the aborted store.
REQ-026 With MISALIGN_TRAP_EN, store to 0x22 → memory unchanged, misalign_err = 1 until reset, wb_reg_write = 0.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS-style memory stage: word-addressed data memory with a fixed-latency access FSM.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic [4:0]  write_reg,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] pcout,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        out_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_reg_write,
    output logic        misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_is_store;
    logic          r_load_wb;
    logic          r_pc_src;
    logic [31:0]   r_branch_target;
    logic [31:0]   r_wb_data;
    logic [4:0]    r_wb_reg;
    logic          r_wb_reg_write;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic w_accept;
    logic w_mem_op;
    logic w_misalign;
    logic w_final;
    logic w_mem_we;

    assign in_ready = (r_state != ST_ACCESS);
    assign w_accept = in_valid & in_ready;
    assign w_mem_op = mem_read | mem_write;
    assign w_final  = (r_state == ST_ACCESS) && (r_cnt == 4'd0);
    assign w_mem_we = w_final & r_is_store;

`ifdef MISALIGN_TRAP_EN
    logic r_misalign_err;

    assign w_misalign = w_mem_op & (alu_result[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign_err <= 1'b0;
        end else if (w_accept & w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`else
    assign w_misalign   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= 4'd0;
            r_idx           <= '0;
            r_wdata         <= 32'd0;
            r_is_store      <= 1'b0;
            r_load_wb       <= 1'b0;
            r_pc_src        <= 1'b0;
            r_branch_target <= 32'd0;
            r_wb_data       <= 32'd0;
            r_wb_reg        <= 5'd0;
            r_wb_reg_write  <= 1'b0;
        end else begin
            r_pc_src <= 1'b0;
            case (r_state)
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_DONE;
                        if (r_load_wb) begin
                            r_wb_data <= r_mem[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state         <= w_mem_op ? ST_ACCESS : ST_DONE;
                        r_cnt           <= LAT_LAST;
                        r_idx           <= alu_result[AW+1:2];
                        r_wdata         <= write_data;
                        // A trapped access neither writes memory nor returns load data.
                        r_is_store      <= mem_write & ~w_misalign;
                        r_load_wb       <= mem_read & ~mem_write & mem_to_reg & ~w_misalign;
                        r_pc_src        <= branch & zero;
                        r_branch_target <= pcout;
                        r_wb_data       <= w_misalign ? 32'd0 : alu_result;
                        r_wb_reg        <= write_reg;
                        r_wb_reg_write  <= reg_write & ~w_misalign;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Memory is deliberately outside the reset domain so its contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign out_valid     = (r_state == ST_DONE);
    assign pc_src        = r_pc_src;
    assign branch_target = r_branch_target;
    assign wb_data       = r_wb_data;
    assign wb_reg        = r_wb_reg;
    assign wb_reg_write  = r_wb_reg_write;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage (DEPTH_WORDS=64, MEM_LATENCY=2).
module tb_mem_stage;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] exp_wb;
        logic        exp_rw;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  write_reg;
    logic        branch;
    logic        zero;
    logic [31:0] pcout;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        out_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_reg_write;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs [9];

    always #5 clk = ~clk;

    mem_stage #(
        .DEPTH_WORDS(64),
        .MEM_LATENCY(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .write_reg    (write_reg),
        .branch       (branch),
        .zero         (zero),
        .pcout        (pcout),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .out_valid    (out_valid),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_reg_write (wb_reg_write),
        .misalign_err (misalign_err)
    );

    task automatic chk(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        alu_result = 32'd0;
        write_data = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        write_reg  = 5'd0;
        branch     = 1'b0;
        zero       = 1'b0;
        pcout      = 32'd0;
    endtask

    function automatic vec_t mkv(input logic rd, input logic wr, input logic m2r, input logic rw,
                                 input logic [4:0] wreg, input logic [31:0] alu,
                                 input logic [31:0] wdata, input logic [31:0] exp_wb,
                                 input logic exp_rw, input int lat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw; v.wreg = wreg;
        v.alu = alu; v.wdata = wdata; v.exp_wb = exp_wb; v.exp_rw = exp_rw; v.exp_lat = lat;
        return v;
    endfunction

    // Called just after a rising edge with the stage able to accept.
    task automatic run_txn(input vec_t v, input string name);
        int lat;
        in_valid   = 1'b1;
        mem_read   = v.rd;
        mem_write  = v.wr;
        mem_to_reg = v.m2r;
        reg_write  = v.rw;
        write_reg  = v.wreg;
        alu_result = v.alu;
        write_data = v.wdata;
        @(posedge clk); #1;
        idle_inputs();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(name, "out_valid", 32'(out_valid), 32'd1);
        chk(name, "latency", 32'(lat), 32'(v.exp_lat));
        chk(name, "wb_data", wb_data, v.exp_wb);
        chk(name, "wb_reg", 32'(wb_reg), 32'(v.wreg));
        chk(name, "wb_reg_write", 32'(wb_reg_write), 32'(v.exp_rw));
        @(posedge clk); #1;
        chk(name, "pulse_end", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h10, 1'b0, 2);
        vecs[1] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 2);
        vecs[2] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h12345678, 32'h0, 32'h12345678, 1'b1, 0);
        vecs[3] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h100, 32'h55, 32'h100, 1'b0, 2);
        vecs[4] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0, 32'h0, 32'h55, 1'b1, 2);
        vecs[5] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h10, 32'h0, 32'h10, 1'b1, 2);
        vecs[6] = mkv(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h14, 32'hCAFEF00D, 32'h14, 1'b0, 2);
        vecs[7] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'h14, 32'h0, 32'hCAFEF00D, 1'b1, 2);
        vecs[8] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h110, 32'h0, 32'hDEADBEEF, 1'b1, 2);

        idle_inputs();
        reset = 1'b0;
        #2;
        chk("reset", "in_ready", 32'(in_ready), 32'd1);
        chk("reset", "out_valid", 32'(out_valid), 32'd0);
        chk("reset", "pc_src", 32'(pc_src), 32'd0);
        chk("reset", "wb_data", wb_data, 32'd0);
        chk("reset", "wb_reg", 32'(wb_reg), 32'd0);
        chk("reset", "wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("reset", "branch_target", branch_target, 32'd0);
        chk("reset", "misalign_err", 32'(misalign_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back ALU ops: one result per cycle, never stalls.
        in_valid  = 1'b1;
        reg_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu_result = 32'(i);
            write_reg  = 5'(i);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d", i), "out_valid", 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d", i), "wb_data", wb_data, 32'(i));
            chk($sformatf("b2b%0d", i), "in_ready", 32'(in_ready), 32'd1);
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("b2b", "out_valid_end", 32'(out_valid), 32'd0);

        // Taken branch, then not-taken branch.
        in_valid = 1'b1; branch = 1'b1; zero = 1'b1; pcout = 32'h40;
        @(posedge clk); #1;
        idle_inputs();
        chk("br_taken", "pc_src", 32'(pc_src), 32'd1);
        chk("br_taken", "branch_target", branch_target, 32'h40);
        @(posedge clk); #1;
        chk("br_taken", "pc_src_drop", 32'(pc_src), 32'd0);
        chk("br_taken", "target_hold", branch_target, 32'h40);
        in_valid = 1'b1; branch = 1'b1; zero = 1'b0; pcout = 32'h80;
        @(posedge clk); #1;
        idle_inputs();
        chk("br_not", "pc_src", 32'(pc_src), 32'd0);
        chk("br_not", "branch_target", branch_target, 32'h80);
        @(posedge clk); #1;

        // Reset in the middle of a store must leave memory untouched.
        run_txn(mkv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'hAAAA5555, 32'h20, 1'b0, 2), "pre20");
        in_valid = 1'b1; mem_write = 1'b1; alu_result = 32'h20; write_data = 32'h1234;
        @(posedge clk); #1;
        idle_inputs();
        chk("abort", "in_ready_access", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort", "in_ready_access2", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort", "in_ready_rst", 32'(in_ready), 32'd1);
        chk("abort", "out_valid_rst", 32'(out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort", "out_valid_held", 32'(out_valid), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort", "out_valid_after", 32'(out_valid), 32'd0);
        end
        run_txn(mkv(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h20, 32'h0, 32'hAAAA5555, 1'b1, 2), "ld20");

        // Misaligned store to 0x22 (same word as 0x20).
`ifdef MISALIGN_TRAP_EN
        run_txn(mkv(1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h22, 32'h99, 32'h0, 1'b0, 2), "mis_st");
        chk("mis_st", "misalign_err", 32'(misalign_err), 32'd1);
        run_txn(mkv(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h20, 32'h0, 32'hAAAA5555, 1'b1, 2), "mis_ld");
        chk("mis_ld", "misalign_err", 32'(misalign_err), 32'd1);
`else
        run_txn(mkv(1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h22, 32'h99, 32'h22, 1'b1, 2), "mis_st");
        chk("mis_st", "misalign_err", 32'(misalign_err), 32'd0);
        run_txn(mkv(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h20, 32'h0, 32'h99, 1'b1, 2), "mis_ld");
        chk("mis_ld", "misalign_err", 32'(misalign_err), 32'd0);
`endif

        // Reset asserted between edges must clear outputs immediately.
        reset = 1'b0;
        #1;
        chk("async_rst", "wb_data", wb_data, 32'd0);
        chk("async_rst", "wb_reg", 32'(wb_reg), 32'd0);
        chk("async_rst", "wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("async_rst", "misalign_err", 32'(misalign_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
